// File: rtl/wb_regfile.sv
// wb_regfile: dual-write, quad-read architectural register file with a 64-bit retire counter.
// Latency: writes land at the rising edge, reads are combinational; WB_REGFILE_BYPASS_EN adds same-cycle write forwarding.
// Backpressure: none; every presented write and commit is accepted on every edge.
module wb_regfile #(
    parameter int REG_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int READ_PORTS = 4,
    localparam int AW        = $clog2(REG_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            we,
    input  logic [1:0][AW-1:0]                    waddr,
    input  logic [1:0][DATA_WIDTH-1:0]            wdata,
    input  logic [1:0]                            commit_valid,
    input  logic [READ_PORTS-1:0][AW-1:0]         raddr,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rdata,
    output logic [63:0]                           retire_cnt
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [63:0]           cnt_q;
    logic [1:0]            wr_act;

    // A write to r0 is dropped here so neither the array nor the bypass ever sees it.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_act[k] = we[k] && (waddr[k] != '0);
        end
    end

    // Slot 1 is younger, so it is tested first and shadows slot 0 on an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (wr_act[1] && (waddr[1] == AW'(i))) begin
                    regs[i] <= wdata[1];
                end else if (wr_act[0] && (waddr[0] == AW'(i))) begin
                    regs[i] <= wdata[0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 64'(commit_valid[0]) + 64'(commit_valid[1]);
        end
    end

    assign retire_cnt = cnt_q;

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rdata[p] = '0;
            if (raddr[p] != '0) begin
                rdata[p] = regs[raddr[p]];
`ifdef WB_REGFILE_BYPASS_EN
                if (wr_act[0] && (waddr[0] == raddr[p])) begin
                    rdata[p] = wdata[0];
                end
                if (wr_act[1] && (waddr[1] == raddr[p])) begin
                    rdata[p] = wdata[1];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: array/counter model checked every negedge plus literal spot checks.
module tb_wb_regfile;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        we;
    logic [1:0][4:0]   waddr;
    logic [1:0][31:0]  wdata;
    logic [1:0]        commit_valid;
    logic [3:0][4:0]   raddr;
    logic [3:0][31:0]  rdata;
    logic [63:0]       retire_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .commit_valid (commit_valid),
        .raddr        (raddr),
        .rdata        (rdata),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file semantics: slots applied oldest first, so the younger one ends up stored.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we[k] && waddr[k] != 0) m_regs[waddr[k]] = wdata[k];
            end
            m_cnt = m_cnt + commit_valid[0] + commit_valid[1];
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
        if (we[1] && waddr[1] == a) return wdata[1];
        if (we[0] && waddr[0] == a) return wdata[0];
`endif
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int p = 0; p < 4; p++) begin
                check($sformatf("model_rdata%0d", p), 64'(rdata[p]), 64'(exp_read(raddr[p])));
            end
            check("model_retire_cnt", retire_cnt, m_cnt);
        end
    end

    task automatic present(input logic [1:0] w, input int a0, input logic [31:0] d0,
                           input int a1, input logic [31:0] d1, input logic [1:0] cv);
        we           = w;
        waddr[0]     = 5'(a0);
        wdata[0]     = d0;
        waddr[1]     = 5'(a1);
        wdata[1]     = d1;
        commit_valid = cv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we           = '0;
        commit_valid = '0;
    endtask

    task automatic set_raddr(input int r0, input int r1, input int r2, input int r3);
        raddr[0] = 5'(r0);
        raddr[1] = 5'(r1);
        raddr[2] = 5'(r2);
        raddr[3] = 5'(r3);
    endtask

    initial begin
        rst = 1'b1;
        present(2'b00, 0, '0, 0, '0, 2'b00);
        set_raddr(0, 0, 0, 0);
        #12;
        for (int p = 0; p < 4; p++) check("reset_rdata", 64'(rdata[p]), 64'h0);
        check("reset_retire", retire_cnt, 64'h0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Write r5, then assert reset between edges.
        set_raddr(5, 0, 0, 0);
        present(2'b01, 5, 32'h0000_1234, 0, '0, 2'b11);
        tick();
        check("r5_written", 64'(rdata[0]), 64'h1234);
        check("retire_two", retire_cnt, 64'd2);
        #1 rst = 1'b1;
        #1;
        check("async_reset_r5", 64'(rdata[0]), 64'h0);
        check("async_reset_retire", retire_cnt, 64'h0);
        rst = 1'b0;

        // Dual write, distinct addresses, first edge after reset release.
        set_raddr(3, 7, 5, 9);
        present(2'b11, 3, 32'hAAAA_0001, 7, 32'hBBBB_0002, 2'b10);
        tick();
        check("dual_r3", 64'(rdata[0]), 64'hAAAA_0001);
        check("dual_r7", 64'(rdata[1]), 64'hBBBB_0002);
        check("dual_r5_untouched", 64'(rdata[2]), 64'h0);
        check("dual_r9_untouched", 64'(rdata[3]), 64'h0);

        // Same-address conflict: younger slot wins.
        present(2'b11, 9, 32'h1111_1111, 9, 32'h2222_2222, 2'b01);
        #2;
`ifdef WB_REGFILE_BYPASS_EN
        check("conflict_same_cycle", 64'(rdata[3]), 64'h2222_2222);
`else
        check("conflict_same_cycle", 64'(rdata[3]), 64'h0);
`endif
        tick();
        check("conflict_after", 64'(rdata[3]), 64'h2222_2222);

        // Writes to r0 are dropped.
        set_raddr(0, 3, 7, 9);
        present(2'b11, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 2'b00);
        #2;
        check("r0_same_cycle", 64'(rdata[0]), 64'h0);
        tick();
        check("r0_after", 64'(rdata[0]), 64'h0);

        // Bypass visibility of r12.
        set_raddr(12, 3, 7, 9);
        present(2'b01, 12, 32'hDEAD_BEEF, 0, '0, 2'b00);
        #2;
`ifdef WB_REGFILE_BYPASS_EN
        check("r12_same_cycle", 64'(rdata[0]), 64'hDEAD_BEEF);
`else
        check("r12_same_cycle", 64'(rdata[0]), 64'h0);
`endif
        tick();
        check("r12_after", 64'(rdata[0]), 64'hDEAD_BEEF);
        check("retire_after_writes", retire_cnt, 64'd2);

        // Spread of directed writes across the array, model checks each cycle.
        for (int i = 1; i <= 8; i++) begin
            set_raddr(i, i + 16, i - 1, i + 15);
            present(2'b11, i, 32'h0101_0101 * 32'(i), i + 16, ~(32'h0101_0101 * 32'(i)), 2'(i));
            tick();
        end
        set_raddr(4, 20, 12, 9);
        #2;
        check("spread_r4", 64'(rdata[0]), 64'h0404_0404);
        check("spread_r20", 64'(rdata[1]), 64'hFBFB_FBFB);

        // Retire pattern {2,1,0,2} from a fresh reset.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        present(2'b00, 0, '0, 0, '0, 2'b11); tick();
        present(2'b00, 0, '0, 0, '0, 2'b01); tick();
        present(2'b00, 0, '0, 0, '0, 2'b00); tick();
        present(2'b00, 0, '0, 0, '0, 2'b11); tick();
        check("retire_pattern", retire_cnt, 64'd5);

        // Wrap at 2^64.
        #1;
        dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt     = 64'hFFFF_FFFF_FFFF_FFFF;
        present(2'b00, 0, '0, 0, '0, 2'b11);
        tick();
        check("retire_wrap", retire_cnt, 64'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural general-purpose register file at the receiving end of the dual-issue write-back stage. Accepts up to two register writes per cycle from the write-back register outputs, serves four combinational read ports to the decode/dispatch stage, and keeps a 64-bit retired-instruction counter fed by the per-slot commit valids. The top level unpacks the write-back and commit-control structures into the flat ports below.

## Interface

- `REG_NUM`, 32: number of architectural registers; register 0 is hardwired zero.
- `DATA_WIDTH`, 32: register width in bits.
- `READ_PORTS`, 4: number of read ports, two per issue slot.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `we` input [2]: per-slot write enable, slot 0 older, slot 1 younger.
- `waddr` input [2][$clog2(REG_NUM)]: per-slot destination register.
- `wdata` input [2][DATA_WIDTH]: per-slot write data.
- `commit_valid` input [2]: per-slot instruction retired this cycle, independent of `we`.
- `raddr` input [READ_PORTS][$clog2(REG_NUM)]: read addresses.
- `rdata` output [READ_PORTS][DATA_WIDTH]: read data, combinational.
- `retire_cnt` output 64: total retired instructions since reset.

## Operation

- Storage: `REG_NUM` x `DATA_WIDTH` array. Entry 0 is never written and always reads 0.
- Write rules per rising edge:
  - Slot k writes `wdata[k]` to `waddr[k]` when `we[k]`=1 and `waddr[k]`!=0.
  - Both slots valid with the same nonzero address: slot 1 (younger) wins, and slot 0's data is discarded.
  - `we`=1 with address 0 is silently dropped.
- Read: `rdata[i]` = 0 if `raddr[i]`==0; otherwise the array entry, modified by bypass (see Configuration).
- Retire counter:
  - `retire_cnt` += `commit_valid[0]` + `commit_valid[1]` each edge, giving an increment of 0, 1 or 2.
  - Unsigned 64-bit arithmetic; wraps from 2^64-1 to 0 (or 1) modulo 2^64.
- The block has no stall or flush input. The upstream write-back register already zeroes `we`/`commit_valid` on flush and holds them on pause. A held write re-writes identical data, which is harmless. A held commit_valid counts again, so upstream must deassert commit_valid while paused.

## Timing

- Reset (`rst`=1, asynchronous): every array entry is 0 and `retire_cnt`=0 immediately. `rdata` then reads 0 on all ports.
- Reset released mid-operation: writes presented on the first edge after deassertion are accepted normally.
- Write latency: the array updates at the edge where `we` is sampled. Read latency is 0 cycles, purely combinational from `raddr`.
- With bypass, a write is visible on `rdata` in the same cycle it is presented. Without bypass, it is visible the cycle after that edge.
- `retire_cnt` reflects commits up to and including the previous edge.

## Configuration

- Macro `WB_REGFILE_BYPASS_EN`.
- Defined: a read port whose nonzero `raddr` matches an active write returns that write's `wdata` combinationally.
  - If both slots match, slot 1 data is returned.
  - Address 0 is never bypassed.
- Not defined: reads return the array contents only, and the same-cycle write is not visible until after the edge. Decode must then cover the one-cycle window through its own forwarding.

## Test plan

- Reset: write r5=0x1234, assert `rst` asynchronously between edges. Required response: `rdata` for r5 = 0 and `retire_cnt`=0 without waiting for a clock edge.
- Dual write, distinct addresses: slot0 r3=0xAAAA_0001 and slot1 r7=0xBBBB_0002 in one cycle. Required response: next cycle, reads of r3/r7 return those values and all other ports are unchanged.
- Same-address conflict: slot0 r9=0x1111_1111, slot1 r9=0x2222_2222. Required response: after the edge, r9 = 0x2222_2222. With bypass, the same-cycle read of r9 also = 0x2222_2222.
- Register zero: `we`=1, `waddr`=0, `wdata`=0xFFFF_FFFF on both slots. Required response: r0 reads 0 in the same cycle and afterwards.
- Bypass on/off: write r12=0xDEAD_BEEF with `raddr[0]`=12 in the same cycle. Required response: bypass build returns 0xDEAD_BEEF in that cycle; non-bypass build returns the old value in that cycle and 0xDEAD_BEEF the next cycle.
- Retire counter: the commit pattern {2,1,0,2} over four cycles gives `retire_cnt`=5. Force the counter near 2^64-1 and commit 2; it must wrap to 1.
